// File: rtl/q1_response_checker.sv
// q1_response_checker
//   Response end of the q1 gate stimulus flow. Accepts an applied vector
//   {a,b,c}, waits SETTLE_CYCLES clocks for the gate outputs to settle, then
//   compares the observed {y1,y0} with the expected truth table. It keeps
//   mismatch/coverage statistics alongside the comparison.
//
// Parameters
//   SETTLE_CYCLES  clocks from vector accept to output sample (1..255)
//   EXP_Y0/EXP_Y1  expected y0/y1 indexed by vector {a,b,c}
//   CNT_W          mismatch counter width
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   clear          statistics clear (FSM state is left alone)
//   vec_valid/vec  new vector {a,b,c}
//   y              observed {y1,y0} from q1 (compared unregistered)
//   busy           vector is in its settle window
//   res_valid      1-cycle result pulse; res_ok/res_vec qualify it
//   mismatch_cnt   saturating failed-comparison count
//   vec_seen       bit i set once vector i has been checked; all_seen = &vec_seen
//   err, drop      sticky: any mismatch / vec_valid while not idle
//
// Optional feature, macro TRANS_COV_EN:
//   trans_seen[{prev,cur}] records every checked vector-to-vector transition;
//   trans_all = &trans_seen.
//
// state  | meaning
// IDLE   | waiting for vec_valid
// SETTLE | settle counter running down to 0
// CHECK  | sample y, publish result, update statistics

module q1_response_checker #(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] EXP_Y0        = 8'h96,
  parameter logic [7:0] EXP_Y1        = 8'hE8,
  parameter int         CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             vec_valid,
  input  logic [2:0]       vec,
  input  logic [1:0]       y,
  output logic             busy,
  output logic             res_valid,
  output logic             res_ok,
  output logic [2:0]       res_vec,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [7:0]       vec_seen,
  output logic             all_seen,
  output logic             err,
`ifdef TRANS_COV_EN
  output logic [63:0]      trans_seen,
  output logic             trans_all,
`endif
  output logic             drop
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_t;

  state_t     state, state_nxt;
  logic [7:0] settle_cnt, settle_cnt_nxt;
  logic       check, match, accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    case (state)
      IDLE: begin
        if (vec_valid) begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = 8'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (settle_cnt == 8'd0) state_nxt = CHECK;
        else                    settle_cnt_nxt = settle_cnt - 8'd1;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = (state == IDLE) && vec_valid;
  assign check     = (state == CHECK);
  assign match     = (y == {EXP_Y1[res_vec], EXP_Y0[res_vec]});
  assign busy      = (state == SETTLE);
  assign res_valid = check;
  assign res_ok    = check && match;
  assign all_seen  = &vec_seen;

  always_ff @(posedge clk) begin
    if (rst)         res_vec <= '0;
    else if (accept) res_vec <= vec;
  end

  // Statistics: clear first produces a base value, then the CHECK update is
  // applied on top, so a coincident CHECK survives the clear.
  logic [CNT_W-1:0] cnt_base, cnt_nxt;
  logic [7:0]       seen_nxt;
  logic             err_nxt, drop_nxt;

  always_comb begin
    cnt_base = clear ? '0 : mismatch_cnt;
    cnt_nxt  = cnt_base;
    seen_nxt = clear ? '0 : vec_seen;
    err_nxt  = clear ? 1'b0 : err;
    drop_nxt = (clear ? 1'b0 : drop) | (vec_valid && (state != IDLE));
    if (check) begin
      seen_nxt[res_vec] = 1'b1;
      if (!match) begin
        err_nxt = 1'b1;
        if (cnt_base != {CNT_W{1'b1}}) cnt_nxt = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_cnt <= '0;
      vec_seen     <= '0;
      err          <= 1'b0;
      drop         <= 1'b0;
    end else begin
      mismatch_cnt <= cnt_nxt;
      vec_seen     <= seen_nxt;
      err          <= err_nxt;
      drop         <= drop_nxt;
    end
  end

`ifdef TRANS_COV_EN
  logic [2:0]  prev_vec, prev_vec_nxt;
  logic        prev_ok, prev_ok_nxt;
  logic [63:0] trans_nxt;

  always_comb begin
    prev_vec_nxt = prev_vec;
    prev_ok_nxt  = clear ? 1'b0 : prev_ok;
    trans_nxt    = clear ? '0 : trans_seen;
    if (check) begin
      if (prev_ok_nxt) trans_nxt[{prev_vec, res_vec}] = 1'b1;
      prev_vec_nxt = res_vec;
      prev_ok_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vec   <= '0;
      prev_ok    <= 1'b0;
      trans_seen <= '0;
    end else begin
      prev_vec   <= prev_vec_nxt;
      prev_ok    <= prev_ok_nxt;
      trans_seen <= trans_nxt;
    end
  end

  assign trans_all = &trans_seen;
`endif

endmodule

// File: tb/tb_q1_response_checker.sv
module tb_q1_response_checker;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst, clear, vec_valid;
  logic [2:0] vec;
  logic [1:0] y;
  logic       busy, res_valid, res_ok, all_seen, err, drop;
  logic [2:0] res_vec;
  logic [7:0] mismatch_cnt, vec_seen;
`ifdef TRANS_COV_EN
  logic [63:0] trans_seen;
  logic        trans_all;
`endif

  q1_response_checker #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .clear(clear), .vec_valid(vec_valid), .vec(vec), .y(y),
    .busy(busy), .res_valid(res_valid), .res_ok(res_ok), .res_vec(res_vec),
    .mismatch_cnt(mismatch_cnt), .vec_seen(vec_seen), .all_seen(all_seen),
    .err(err),
`ifdef TRANS_COV_EN
    .trans_seen(trans_seen), .trans_all(trans_all),
`endif
    .drop(drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: a pending vector with its due cycle plus plain stats.
  int          cyc = 0;
  logic        m_pend = 0;
  int          m_due = 0;
  logic [2:0]  m_vec = 0;
  logic [7:0]  m_cnt = 0, m_seen = 0;
  logic        m_err = 0, m_drop = 0;
  logic        m_pv = 0;
  logic [2:0]  m_prev = 0;
  logic [63:0] m_trans = 0;

  logic [5:0]  obs_out, exp_out;   // {busy, res_valid, res_ok, res_vec}
  logic [18:0] obs_stat, exp_stat; // {cnt, seen, all_seen, err, drop}
  logic [63:0] obs_trans;

  // Full-adder truth: y1 = carry (two or more ones), y0 = sum (odd ones).
  function automatic logic [1:0] fa(input logic [2:0] v);
    int ones;
    ones = int'(v[0]) + int'(v[1]) + int'(v[2]);
    return {ones >= 2, (ones % 2) == 1};
  endfunction

  function automatic logic check_now();
    return m_pend && (cyc == m_due);
  endfunction

  task automatic drive(input logic vv, input logic [2:0] v, input logic [1:0] yy,
                       input logic clr, input logic rr);
    logic chk, inflight;
    vec_valid = vv; vec = v; y = yy; clear = clr; rst = rr;
    @(negedge clk);
    obs_out  = {busy, res_valid, res_ok, res_vec};
    obs_stat = {mismatch_cnt, vec_seen, all_seen, err, drop};
`ifdef TRANS_COV_EN
    obs_trans = trans_seen;
`else
    obs_trans = '0;
`endif
    chk      = check_now();
    inflight = m_pend;
    exp_out  = {m_pend && (cyc < m_due), chk, chk && (yy == fa(m_vec)), m_vec};
    exp_stat = {m_cnt, m_seen, &m_seen, m_err, m_drop};
    if (rr) begin
      m_pend = 0; m_vec = 0; m_cnt = 0; m_seen = 0; m_err = 0; m_drop = 0;
      m_pv = 0; m_trans = 0;
    end else begin
      if (clr) begin
        m_cnt = 0; m_seen = 0; m_err = 0; m_drop = 0; m_pv = 0; m_trans = 0;
      end
      if (chk) begin
        m_seen[m_vec] = 1'b1;
        if (yy != fa(m_vec)) begin
          m_err = 1;
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        if (m_pv) m_trans[{m_prev, m_vec}] = 1'b1;
        m_prev = m_vec; m_pv = 1; m_pend = 0;
      end
      if (vv) begin
        if (inflight) m_drop = 1;
        else begin m_pend = 1; m_vec = v; m_due = cyc + S + 1; end
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(0, 3'd0, 2'd0, 0, 1);
    drive(0, 3'd0, 2'd0, 0, 1);
    drive(0, 3'd0, 2'd0, 0, 0);
    n_cmp++;
    if (obs_out !== 6'd0 || obs_stat !== 19'd0) begin
      n_mis++;
      $display("FAIL reset out=%h stat=%h required 0/0", obs_out, obs_stat);
    end
  endtask

  task automatic test_all_vectors();
    int t_acc, lat, pulses;
    pulses = 0;
    for (int v = 0; v < 8; v++) begin
      t_acc = cyc; lat = -1;
      drive(1, 3'(v), 2'($urandom), 0, 0);
      for (int k = 0; k < S + 1; k++) begin
        drive(0, 3'($urandom), fa(m_vec), 0, 0);
        if (obs_out[4] === 1'b1) begin lat = cyc - 1 - t_acc; pulses++; end
        n_cmp++;
        if (obs_out !== exp_out) begin
          n_mis++; $display("FAIL vec%0d out=%h required %h", v, obs_out, exp_out);
        end
      end
      n_cmp++;
      if (lat != S + 1) begin
        n_mis++; $display("FAIL latency vec%0d got %0d required %0d", v, lat, S + 1);
      end
    end
    drive(0, 3'd0, 2'd0, 0, 0);
    n_cmp++;
    if (obs_stat !== exp_stat || obs_stat !== {8'h00, 8'hFF, 3'b100} || pulses != 8) begin
      n_mis++;
      $display("FAIL all_vectors stat=%h pulses=%0d required %h/8", obs_stat, pulses, exp_stat);
    end
  endtask

  task automatic test_stuck_carry();
    drive(0, 3'd0, 2'd0, 1, 0);
    drive(1, 3'd7, 2'd0, 0, 0);
    for (int k = 0; k < S + 1; k++) begin
      drive(0, 3'd0, 2'b01, 0, 0);
      n_cmp++;
      if (obs_out !== exp_out) begin
        n_mis++; $display("FAIL stuck_carry out=%h required %h", obs_out, exp_out);
      end
    end
    drive(0, 3'd0, 2'b01, 0, 0);
    n_cmp++;
    if (obs_stat !== exp_stat || obs_stat !== {8'h01, 8'h80, 3'b010}) begin
      n_mis++; $display("FAIL stuck_carry stat=%h required %h", obs_stat, exp_stat);
    end
  endtask

  task automatic test_drop();
    int pulses;
    logic [2:0] v1;
    pulses = 0;
    v1 = 3'($urandom);
    drive(0, 3'd0, 2'd0, 1, 0);
    drive(1, v1, 2'd0, 0, 0);
    drive(0, 3'd0, 2'd0, 0, 0);
    drive(1, ~v1, 2'd0, 0, 0);
    for (int k = 0; k < 3 * S; k++) begin
      drive(0, 3'd0, fa(v1), 0, 0);
      if (obs_out[4] === 1'b1) pulses++;
      n_cmp++;
      if (obs_out !== exp_out) begin
        n_mis++; $display("FAIL drop out=%h required %h", obs_out, exp_out);
      end
    end
    n_cmp++;
    if (obs_stat !== exp_stat || obs_stat[0] !== 1'b1 || pulses != 1) begin
      n_mis++; $display("FAIL drop stat=%h pulses=%0d required %h/1", obs_stat, pulses, exp_stat);
    end
  endtask

  task automatic test_back_to_back();
    int last, gap_bad, pulses;
    last = -1; gap_bad = 0; pulses = 0;
    drive(0, 3'd0, 2'd0, 1, 0);
    for (int k = 0; k < 10 * (S + 2); k++) begin
      drive(1, 3'($urandom), fa(m_vec), 0, 0);
      if (obs_out[4] === 1'b1) begin
        if (last >= 0 && (cyc - last) != S + 2) gap_bad++;
        last = cyc; pulses++;
      end
      n_cmp++;
      if (obs_out !== exp_out) begin
        n_mis++; $display("FAIL back_to_back out=%h required %h", obs_out, exp_out);
      end
    end
    n_cmp++;
    if (gap_bad != 0 || pulses < 9) begin
      n_mis++; $display("FAIL back_to_back spacing bad=%0d pulses=%0d required 0/>=9", gap_bad, pulses);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 2) == 0, 3'($urandom),
            ($urandom_range(0, 1) == 1) ? fa(m_vec) : 2'($urandom),
            $urandom_range(0, 40) == 0, 0);
      n_cmp++;
      if (obs_out !== exp_out || obs_stat !== exp_stat) begin
        n_mis++;
        $display("FAIL random c%0d out=%h stat=%h required %h %h", cyc, obs_out, obs_stat, exp_out, exp_stat);
      end
    end
  endtask

  task automatic test_saturate();
    int results;
    results = 0;
    drive(0, 3'd0, 2'd0, 1, 0);
    for (int k = 0; k < 2500 && results < 300; k++) begin
      drive(1, 3'($urandom), ~fa(m_vec), 0, 0);
      if (obs_out[4] === 1'b1) results++;
      n_cmp++;
      if (obs_out !== exp_out) begin
        n_mis++; $display("FAIL saturate out=%h required %h", obs_out, exp_out);
      end
    end
    drive(0, 3'd0, 2'd0, 0, 0);
    n_cmp++;
    if (results != 300 || obs_stat[18:11] !== 8'hFF || obs_stat !== exp_stat) begin
      n_mis++;
      $display("FAIL saturate results=%0d stat=%h required 300/%h", results, obs_stat, exp_stat);
    end
    drive(1, 3'd5, 2'd0, 0, 0);
    for (int k = 0; k < S + 3; k++)
      drive(0, 3'd0, ~fa(m_vec), check_now(), 0);
    n_cmp++;
    if (obs_stat !== exp_stat || obs_stat[18:11] !== 8'h01 || obs_stat[1] !== 1'b1
        || obs_stat[10:3] !== 8'h20) begin
      n_mis++; $display("FAIL clear_vs_check stat=%h required %h", obs_stat, exp_stat);
    end
  endtask

  task automatic test_rst_abort();
    int pulses;
    pulses = 0;
    drive(1, 3'($urandom), 2'd0, 0, 0);
    drive(0, 3'd0, 2'd0, 0, 0);
    drive(0, 3'd0, 2'd0, 0, 1);
    for (int k = 0; k < 2 * S; k++) begin
      drive(0, 3'd0, 2'd0, 0, 0);
      if (obs_out[4] === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || obs_out !== 6'd0 || obs_stat !== 19'd0 || obs_trans !== 64'd0) begin
      n_mis++;
      $display("FAIL rst_abort pulses=%0d out=%h stat=%h trans=%h required none/0",
               pulses, obs_out, obs_stat, obs_trans);
    end
  endtask

`ifdef TRANS_COV_EN
  task automatic test_trans();
    logic [63:0] used;
    logic [2:0]  seq [$];
    logic [2:0]  last;
    logic        found;
    used = '0; last = 3'd0; seq.push_back(3'd0);
    do begin
      found = 0;
      for (int s = 7; s >= 0 && !found; s--)
        if (!used[{last, 3'(s)}]) begin
          used[{last, 3'(s)}] = 1'b1; last = 3'(s); seq.push_back(last); found = 1;
        end
    end while (found);
    drive(0, 3'd0, 2'd0, 0, 1);
    foreach (seq[i]) begin
      drive(1, seq[i], 2'd0, 0, 0);
      for (int k = 0; k < S + 1; k++) drive(0, 3'd0, fa(m_vec), 0, 0);
    end
    drive(0, 3'd0, 2'd0, 0, 0);
    n_cmp++;
    if (obs_trans !== m_trans || trans_all !== 1'b1 || seq.size() != 65) begin
      n_mis++;
      $display("FAIL trans_all trans=%h all=%b len=%0d required %h/1/65",
               obs_trans, trans_all, seq.size(), m_trans);
    end
  endtask
`endif

  initial begin
    rst = 1; clear = 0; vec_valid = 0; vec = 0; y = 0;
    @(posedge clk); #1;
    test_reset();
    test_all_vectors();
    test_stuck_carry();
    test_drop();
    test_back_to_back();
    test_random();
    test_saturate();
`ifdef TRANS_COV_EN
    test_trans();
`endif
    test_rst_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
